// File: rtl/bpred_upd_arb_if.sv
// Request, flush/hold and update bundle for the branch predictor update arbiter.
// master = requester/predictor side, slave = the arbiter.
interface bpred_upd_arb_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_eip;
  logic [31:0] a_target;
  logic        a_taken;
  logic        a_mispred;

  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_eip;
  logic [31:0] b_target;
  logic        b_taken;
  logic        b_mispred;

  logic        flush;
  logic        hold;

  logic        update_valid;
  logic [31:0] update_eip;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_mispred;
  logic [PTR_W:0] count;

  modport master (
    output a_valid, a_eip, a_target, a_taken, a_mispred,
    output b_valid, b_eip, b_target, b_taken, b_mispred,
    output flush, hold,
    input  a_ready, b_ready,
    input  update_valid, update_eip, update_target,
    input  update_taken, update_mispred, count
  );

  modport slave (
    input  a_valid, a_eip, a_target, a_taken, a_mispred,
    input  b_valid, b_eip, b_target, b_taken, b_mispred,
    input  flush, hold,
    output a_ready, b_ready,
    output update_valid, update_eip, update_target,
    output update_taken, update_mispred, count
  );
endinterface

// File: rtl/bpred_upd_arb.sv
// Round-robin A/B branch update arbiter feeding an in-order update FIFO.
// Optional same-cycle bypass on an empty queue: BPRED_UPD_BYPASS_EN.
module bpred_upd_arb #(
  parameter int DEPTH = 4
) (
  input logic           CLK,
  input logic           reset,
  bpred_upd_arb_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] eip;
    logic [31:0] target;
    logic        taken;
    logic        mispred;
  } ent_t;

  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic [PTR_W:0]   cnt_nxt;
  logic             last_grant;

  logic arb_ok;
  logic gnt_a;
  logic gnt_b;
  logic enq;
  logic deq;
  logic byp;
  logic wr;
  ent_t req;
  ent_t upd;

  // Full blocks grants even when a dequeue frees a slot this cycle.
  assign arb_ok = reset & ~bus.flush & (cnt != FULL);
  assign gnt_a  = arb_ok & bus.a_valid
                & (~bus.b_valid | last_grant);
  assign gnt_b  = arb_ok & bus.b_valid
                & (~bus.a_valid | ~last_grant);
  assign enq    = gnt_a | gnt_b;
  assign deq    = reset & ~bus.flush & ~bus.hold
                & (cnt != '0);

`ifdef BPRED_UPD_BYPASS_EN
  assign byp = enq & ~bus.hold & (cnt == '0);
`else
  assign byp = 1'b0;
`endif

  assign wr = enq & ~byp;

  assign req = gnt_b
    ? {bus.b_eip, bus.b_target, bus.b_taken, bus.b_mispred}
    : {bus.a_eip, bus.a_target, bus.a_taken, bus.a_mispred};

  always_comb begin
    upd = '0;
    unique case (1'b1)
      deq:     upd = mem[rd_ptr];
      byp:     upd = req;
      default: upd = '0;
    endcase
  end

  assign bus.a_ready        = gnt_a;
  assign bus.b_ready        = gnt_b;
  assign bus.update_valid   = deq | byp;
  assign bus.update_eip     = upd.eip;
  assign bus.update_target  = upd.target;
  assign bus.update_taken   = upd.taken;
  assign bus.update_mispred = upd.mispred;
  assign bus.count          = cnt;

  assign cnt_nxt = cnt
                 + {{PTR_W{1'b0}}, wr}
                 - {{PTR_W{1'b0}}, deq};

  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_grant <= 1'b1;
    end else if (bus.flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq) last_grant <= gnt_b;
    end
  end

  // Storage is never cleared; only pointers and count are.
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= req;
  end
endmodule
